// File: rtl/d7s_pkg.sv
// Shared constants and types for the D7S seven-segment capture path.
// Segment constants use a..g order with a in bit 6.
package d7s_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned NDIG    = 3;
  localparam int unsigned FRAME_W = NDIG * BCD_W;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [BCD_W-1:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // Digit frame: [2]=hundreds, [1]=tens, [0]=units
  typedef logic [NDIG-1:0][BCD_W-1:0] frame_t;

  function automatic logic is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/d7s_seg_decode.sv
// Combinational seven-segment pattern to BCD decoder.
// Blank decodes to BCD_BLANK without error; unknown patterns flag an error.
module d7s_seg_decode
  import d7s_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [BCD_W-1:0] o_bcd_c,
  output logic             o_err_c
);

  always_comb begin
    o_bcd_c = BCD_ERR;
    o_err_c = 1'b1;
    case (i_seg)
      SEG_0:     begin o_bcd_c = BCD_W'(0); o_err_c = 1'b0; end
      SEG_1:     begin o_bcd_c = BCD_W'(1); o_err_c = 1'b0; end
      SEG_2:     begin o_bcd_c = BCD_W'(2); o_err_c = 1'b0; end
      SEG_3:     begin o_bcd_c = BCD_W'(3); o_err_c = 1'b0; end
      SEG_4:     begin o_bcd_c = BCD_W'(4); o_err_c = 1'b0; end
      SEG_5:     begin o_bcd_c = BCD_W'(5); o_err_c = 1'b0; end
      SEG_6:     begin o_bcd_c = BCD_W'(6); o_err_c = 1'b0; end
      SEG_7:     begin o_bcd_c = BCD_W'(7); o_err_c = 1'b0; end
      SEG_8:     begin o_bcd_c = BCD_W'(8); o_err_c = 1'b0; end
      SEG_9:     begin o_bcd_c = BCD_W'(9); o_err_c = 1'b0; end
      SEG_BLANK: begin o_bcd_c = BCD_BLANK; o_err_c = 1'b0; end
      default:   begin o_bcd_c = BCD_ERR;   o_err_c = 1'b1; end
    endcase
  end

endmodule

// File: rtl/d7s_capture.sv
// Receive side of a multiplexed 3-digit seven-segment bus: synchronizes, filters
// mux ghosting, decodes stable digits and publishes coherent 3-digit frames.
module d7s_capture
  import d7s_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEG_W-1:0]   seg_in,
  input  logic [SEL_W-1:0]   dig_sel,
  output logic [FRAME_W-1:0] bcd_out,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               stale
);

  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PAT_W  = SEL_W + SEG_W;

  logic [SEG_W-1:0]  r_seg_s1, r_seg_s2;
  logic [SEL_W-1:0]  r_sel_s1, r_sel_s2;
  logic [PAT_W-1:0]  r_pat_prev;
  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  frame_t            r_shadow, r_bcd;
  logic [NDIG-1:0]   r_seen, w_seen_nxt;
  logic              r_acc, w_acc_nxt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_frame_valid, r_frame_err, r_stale;

  logic [SEG_W-1:0]  w_seg;
  logic [SEL_W-1:0]  w_sel;
  logic [PAT_W-1:0]  w_pat;
  logic              w_onehot, w_pat_chg, w_latch, w_publish, w_timeout;
  logic [BCD_W-1:0]  w_dec_bcd;
  logic              w_dec_err;

  // Two-flop synchronizers on both buses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_pat_prev <= '0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_sel_s1   <= dig_sel;
      r_sel_s2   <= r_sel_s1;
      r_pat_prev <= w_pat;
    end
  end

  assign w_seg     = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
  assign w_sel     = SEL_ACTIVE_LOW ? ~r_sel_s2 : r_sel_s2;
  assign w_pat     = {w_sel, w_seg};
  assign w_onehot  = is_onehot(w_sel);
  assign w_pat_chg = (w_pat != r_pat_prev);

  d7s_seg_decode u_dec (
    .i_seg   (w_seg),
    .o_bcd_c (w_dec_bcd),
    .o_err_c (w_dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Settle FSM: cnt is the run length of identical samples including the current one
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SETTLING;
        end
      end
      SETTLING: begin
        if (w_pat_chg) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = w_onehot ? SETTLING : IDLE;
        end else if (r_cnt != CNT_W'(SETTLE_CYCLES)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (w_pat_chg) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = w_onehot ? SETTLING : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if ((w_state_nxt == SETTLING) && (w_cnt_nxt == CNT_W'(SETTLE_CYCLES))) begin
      w_latch     = 1'b1;
      w_state_nxt = LOCKED;
    end
  end

  assign w_publish = (r_seen == '1);
  assign w_timeout = !w_latch && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  // A latch in the publish cycle starts the next frame
  always_comb begin
    w_seen_nxt = r_seen;
    w_acc_nxt  = r_acc;
    if (w_publish || w_timeout) begin
      w_seen_nxt = '0;
      w_acc_nxt  = 1'b0;
    end
    if (w_latch) begin
      w_seen_nxt = w_seen_nxt | w_sel;
      w_acc_nxt  = w_acc_nxt | w_dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_seen        <= '0;
      r_acc         <= 1'b0;
      r_bcd         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_idle        <= '0;
      r_stale       <= 1'b0;
    end else begin
      r_seen        <= w_seen_nxt;
      r_acc         <= w_acc_nxt;
      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_bcd       <= r_shadow;
        r_frame_err <= r_acc;
      end
      for (int i = 0; i < NDIG; i++) begin
        if (w_latch && w_sel[i]) r_shadow[i] <= w_dec_bcd;
      end
      if (w_latch) begin
        r_idle  <= '0;
        r_stale <= 1'b0;
      end else if (r_idle != IDLE_W'(TIMEOUT_CYCLES)) begin
        r_idle <= r_idle + IDLE_W'(1);
        if (w_timeout) r_stale <= 1'b1;
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_d7s_capture.sv
// Self-checking bench for d7s_capture: pin-level reference model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_d7s_capture;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 100;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [6:0]  seg_in  = '0;
  logic [2:0]  dig_sel = '0;
  logic [11:0] bcd_out;
  logic        frame_valid, frame_err, stale;

  d7s_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .SEG_ACTIVE_LOW (1'b0),
    .SEL_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode table: index = digit value
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    if (s == 7'h00) return {1'b0, 4'hF};
    for (int i = 0; i < 10; i++) begin
      if (seg_tab[i] == s) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'hE};
  endfunction

  // Reference model: pins seen two edges late; a digit is taken when its one-hot
  // pattern has been identical for exactly SETTLE consecutive samples.
  logic [9:0]  m_s1 = '0, m_s2 = '0, m_prev = '0;
  int          m_run = 0;
  int          m_idle = 0;
  logic [3:0]  m_dig [3] = '{4'h0, 4'h0, 4'h0};
  logic [2:0]  m_seen = '0;
  logic        m_acc = 1'b0, m_pend = 1'b0;
  logic [11:0] exp_bcd = '0;
  logic        exp_fv = 1'b0, exp_err = 1'b0, exp_stale = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [9:0] pat;
    logic [4:0] dec;
    int         d;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0; m_idle = 0;
      for (int i = 0; i < 3; i++) m_dig[i] = 4'h0;
      m_seen = '0; m_acc = 1'b0; m_pend = 1'b0;
      exp_bcd = '0; exp_fv = 1'b0; exp_err = 1'b0; exp_stale = 1'b0;
    end else begin
      pat  = m_s2;
      m_s2 = m_s1;
      m_s1 = {dig_sel, seg_in};
      if (pat == m_prev) m_run = (m_run > int'(SETTLE)) ? m_run : m_run + 1;
      else               m_run = 1;
      m_prev = pat;
      exp_fv = 1'b0;
      if (m_pend) begin
        exp_bcd = {m_dig[2], m_dig[1], m_dig[0]};
        exp_err = m_acc;
        exp_fv  = 1'b1;
        m_seen  = '0;
        m_acc   = 1'b0;
        m_pend  = 1'b0;
      end
      if ($countones(pat[9:7]) == 1 && m_run == int'(SETTLE)) begin
        d   = pat[7] ? 0 : (pat[8] ? 1 : 2);
        dec = ref_decode(pat[6:0]);
        m_dig[d]  = dec[3:0];
        m_seen[d] = 1'b1;
        m_acc     = m_acc | dec[4];
        m_idle    = 0;
        exp_stale = 1'b0;
        if (m_seen == 3'b111) m_pend = 1'b1;
      end else if (m_idle < int'(TMO)) begin
        m_idle++;
        if (m_idle == int'(TMO)) begin
          exp_stale = 1'b1;
          m_seen    = '0;
          m_acc     = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge; also records published frames
  bit          chk_en = 1'b0;
  int          fv_cnt = 0;
  logic [11:0] fv_bcd = '0;
  logic        fv_err = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bcd_out",     32'(bcd_out),     32'(exp_bcd));
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chk("frame_err",   32'(frame_err),   32'(exp_err));
      chk("stale",       32'(stale),       32'(exp_stale));
      if (frame_valid) begin
        fv_cnt++;
        fv_bcd = bcd_out;
        fv_err = frame_err;
      end
    end
  end

  task automatic put(input logic [2:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int f0;

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_bcd",   32'(bcd_out),     32'h0);
    chk("rst_fv",    32'(frame_valid), 32'h0);
    chk("rst_err",   32'(frame_err),   32'h0);
    chk("rst_stale", 32'(stale),       32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // 1: basic frame 015
    f0 = fv_cnt;
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h30, 10); put(3'b100, 7'h7E, 10);
    chk("t1_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t1_bcd",      32'(fv_bcd),      32'h015);
    chk("t1_err",      32'(fv_err),      32'h0);
    chk("t1_model",    32'(exp_bcd),     32'h015);

    // 2: single-cycle ghost patterns between digits are never latched
    f0 = fv_cnt;
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h7F, 1); put(3'b010, 7'h30, 10);
    put(3'b100, 7'h7F, 1);  put(3'b100, 7'h7E, 10);
    chk("t2_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t2_bcd",      32'(fv_bcd),      32'h015);
    chk("t2_err",      32'(fv_err),      32'h0);

    // 3: invalid tens pattern, then a clean frame clears the error
    f0 = fv_cnt;
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h01, 10); put(3'b100, 7'h7E, 10);
    chk("t3_bcd",   32'(fv_bcd), 32'h0E5);
    chk("t3_err",   32'(fv_err), 32'h1);
    chk("t3_model", 32'(exp_err), 32'h1);
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h30, 10); put(3'b100, 7'h7E, 10);
    chk("t3_fv_count", 32'(fv_cnt - f0), 32'd2);
    chk("t3_bcd2",     32'(fv_bcd),      32'h015);
    chk("t3_err2",     32'(fv_err),      32'h0);

    // 4: blank hundreds
    put(3'b001, 7'h7B, 10); put(3'b010, 7'h30, 10); put(3'b100, 7'h00, 10);
    chk("t4_bcd",   32'(fv_bcd),  32'hF19);
    chk("t4_err",   32'(fv_err),  32'h0);
    chk("t4_model", 32'(exp_bcd), 32'hF19);

    // 5: stop after two digits -> stale, partial frame dropped
    f0 = fv_cnt;
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h30, 10);
    put(3'b000, 7'h00, 90);
    chk("t5_not_stale_yet", 32'(stale), 32'h0);
    put(3'b000, 7'h00, 20);
    chk("t5_stale",      32'(stale),       32'h1);
    chk("t5_fv_none",    32'(fv_cnt - f0), 32'd0);
    chk("t5_bcd_holds",  32'(bcd_out),     32'hF19);
    put(3'b100, 7'h33, 10);
    chk("t5_stale_clr",  32'(stale),       32'h0);
    chk("t5_fv_partial", 32'(fv_cnt - f0), 32'd0);
    put(3'b001, 7'h7B, 10); put(3'b010, 7'h5F, 10);
    chk("t5_fv_count",   32'(fv_cnt - f0), 32'd1);
    chk("t5_bcd",        32'(fv_bcd),      32'h469);

    // 6: reset mid-settling discards partial frame
    put(3'b001, 7'h5B, 10); put(3'b010, 7'h30, 10);
    dig_sel = 3'b100; seg_in = 7'h7E;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_bcd",   32'(bcd_out),     32'h0);
    chk("t6_rst_fv",    32'(frame_valid), 32'h0);
    chk("t6_rst_err",   32'(frame_err),   32'h0);
    chk("t6_rst_stale", 32'(stale),       32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    f0 = fv_cnt;
    put(3'b100, 7'h7E, 10); put(3'b001, 7'h7B, 10);
    chk("t6_fv_none",  32'(fv_cnt - f0), 32'd0);
    put(3'b010, 7'h30, 10);
    chk("t6_fv_count", 32'(fv_cnt - f0), 32'd1);
    chk("t6_bcd",      32'(fv_bcd),      32'h019);
    put(3'b000, 7'h00, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
